// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared FSM encodings, stay-timer width and occupancy popcount
package parking_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALLOC = 2'd1;
  localparam logic [1:0] GATE  = 2'd2;

  localparam int STAY_W = 4;

  // Occupancy vectors are zero-padded to four bays before counting.
  function automatic logic [2:0] popcount(input logic [3:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_slot_allocator_if.sv
// rtl/parking_slot_allocator_if.sv - entry-gate sensor inputs and bay status outputs
interface parking_slot_allocator_if
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 3
);

  logic                        arrive;
  logic [NUM_SLOTS-1:0]        depart;
  logic                        gate_open;
  logic                        green;
  logic                        reject;
  logic                        assign_valid;
  logic [1:0]                  assign_slot;
  logic [NUM_SLOTS-1:0]        occupied;
  logic [2:0]                  num_empty;
  logic [STAY_W*NUM_SLOTS-1:0] stay_sec;
  logic [NUM_SLOTS-1:0]        overstay;

  modport master (
    output arrive, depart,
    input  gate_open, green, reject, assign_valid, assign_slot,
    input  occupied, num_empty, stay_sec, overstay
  );

  modport slave (
    input  arrive, depart,
    output gate_open, green, reject, assign_valid, assign_slot,
    output occupied, num_empty, stay_sec, overstay
  );

endinterface

// File: rtl/slot_stay_timer.sv
// rtl/slot_stay_timer.sv - per-bay stay seconds counter, saturating, with overstay flag
module slot_stay_timer
  import parking_pkg::*;
#(
  parameter int MAX_STAY_SEC = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              occupied,
  input  logic              clear,
  output logic [STAY_W-1:0] stay_sec,
  output logic              overstay
);

  logic [STAY_W-1:0] stay_q, stay_d;

  always_comb begin
    stay_d = stay_q;
    if (clear) begin
      stay_d = '0;
    end else if (occupied && tick && (stay_q != '1)) begin
      stay_d = stay_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stay_q <= '0;
    end else begin
      stay_q <= stay_d;
    end
  end

  assign stay_sec = stay_q;
  assign overstay = (32'(stay_q) >= MAX_STAY_SEC);

endmodule

// File: rtl/parking_slot_allocator.sv
// rtl/parking_slot_allocator.sv - entry-gate bay allocator, gate sequencer and occupancy tracker
// PARK_ROUND_ROBIN_EN: rotating search start; undefined gives lowest-free-bay priority.
module parking_slot_allocator
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS     = 3,
  parameter int MAX_STAY_SEC  = 9,
  parameter int GATE_OPEN_SEC = 3
) (
  input logic                     clk,
  input logic                     reset,
  input logic                     tick,
  parking_slot_allocator_if.slave bus
);

  localparam int CNT_W = $clog2(GATE_OPEN_SEC + 1);

  logic [1:0]           state_q, state_d;
  logic                 arrive_q, arrive_d;
  logic                 pending_q, pending_d;
  logic [CNT_W-1:0]     gate_cnt_q, gate_cnt_d;
  logic [NUM_SLOTS-1:0] occupied_q, occupied_d;
  logic [3:0]           occ_pad;
  logic                 arrive_edge;
  logic                 free_found;
  logic [1:0]           free_slot;
  logic                 alloc_fire;
  logic [2:0]           num_empty;

`ifdef PARK_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  int         rr_idx;
`endif

  assign occ_pad     = 4'(occupied_q);
  assign arrive_edge = bus.arrive & ~arrive_q;
  assign num_empty   = 3'(NUM_SLOTS) - popcount(occ_pad);

  // Search uses registered occupancy, so a bay departing this cycle is not handed out yet.
  always_comb begin
    free_found = 1'b0;
    free_slot  = 2'd0;
`ifdef PARK_ROUND_ROBIN_EN
    rr_idx = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_SLOTS) rr_idx = rr_idx - NUM_SLOTS;
      if (!free_found && !occ_pad[rr_idx[1:0]]) begin
        free_found = 1'b1;
        free_slot  = rr_idx[1:0];
      end
    end
`else
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !occ_pad[2'(i)]) begin
        free_found = 1'b1;
        free_slot  = 2'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = ALLOC;
      ALLOC:   state_d = free_found ? GATE : IDLE;
      GATE:    if (tick && (gate_cnt_q == CNT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alloc_fire       = (state_q == ALLOC) & free_found;
    bus.gate_open    = (state_q == GATE);
    bus.assign_valid = alloc_fire;
    bus.assign_slot  = alloc_fire ? free_slot : 2'd0;
    bus.reject       = (state_q == ALLOC) & ~free_found;
    bus.green        = (state_q == IDLE) & (num_empty != 3'd0) & ~pending_q;
  end

  // An edge arriving while one is already pending (which includes all of ALLOC) is dropped.
  always_comb begin
    arrive_d  = bus.arrive;
    pending_d = pending_q;
    if (state_q == ALLOC) begin
      pending_d = 1'b0;
    end else if (arrive_edge) begin
      pending_d = 1'b1;
    end

    gate_cnt_d = gate_cnt_q;
    if (state_q == ALLOC) begin
      gate_cnt_d = CNT_W'(GATE_OPEN_SEC);
    end else if ((state_q == GATE) && tick) begin
      gate_cnt_d = gate_cnt_q - 1'b1;
    end

    occupied_d = occupied_q & ~bus.depart;
    if (alloc_fire) begin
      occupied_d = occupied_d | (NUM_SLOTS'(1) << free_slot);
    end

`ifdef PARK_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
    if (alloc_fire) begin
      rr_ptr_d = ((int'(free_slot) + 1) >= NUM_SLOTS) ? 2'd0 : free_slot + 2'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arrive_q   <= 1'b0;
      pending_q  <= 1'b0;
      gate_cnt_q <= '0;
      occupied_q <= '0;
`ifdef PARK_ROUND_ROBIN_EN
      rr_ptr_q   <= 2'd0;
`endif
    end else begin
      arrive_q   <= arrive_d;
      pending_q  <= pending_d;
      gate_cnt_q <= gate_cnt_d;
      occupied_q <= occupied_d;
`ifdef PARK_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  logic [STAY_W*NUM_SLOTS-1:0] stay_all;
  logic [NUM_SLOTS-1:0]        over_all;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_bay
    slot_stay_timer #(
      .MAX_STAY_SEC(MAX_STAY_SEC)
    ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .occupied (occupied_q[i]),
      .clear    (bus.depart[i] & occupied_q[i]),
      .stay_sec (stay_all[STAY_W*i +: STAY_W]),
      .overstay (over_all[i])
    );
  end

  assign bus.occupied  = occupied_q;
  assign bus.num_empty = num_empty;
  assign bus.stay_sec  = stay_all;
  assign bus.overstay  = over_all;

endmodule

// File: tb/tb_parking_slot_allocator.sv
// tb/tb_parking_slot_allocator.sv - scoreboard bench for parking_slot_allocator
module tb_parking_slot_allocator;

  localparam int N    = 3;
  localparam int MAXS = 9;
  localparam int GOS  = 3;

  logic clk = 1'b0;
  logic reset;
  logic tick;

  always #5 clk = ~clk;

  parking_slot_allocator_if #(.NUM_SLOTS(N)) bus ();

  parking_slot_allocator #(
    .NUM_SLOTS    (N),
    .MAX_STAY_SEC (MAXS),
    .GATE_OPEN_SEC(GOS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tick (tick),
    .bus  (bus)
  );

  typedef struct {
    bit rej;
    int slot;
    int cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         mon_act;
  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         ev_count = 0;
  bit [N-1:0] m_occ;
  int         m_stay[N];
  int         m_rr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Every assign_valid or reject pulse consumes one expectation.
  always @(negedge clk) begin
    if (!reset && (bus.assign_valid || bus.reject)) begin
      ev_count++;
      mon_act = (bus.reject ? 100 : 0) + (bus.assign_valid ? 10 : 0) + int'(bus.assign_slot);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", mon_act, -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_event", mon_act, mon_e.rej ? 100 : 10 + mon_e.slot);
        if (mon_e.cyc >= 0) chk("sb_latency", cyc, mon_e.cyc);
      end
    end
  end

  function automatic int pick(input bit [N-1:0] occ, input int rr);
    for (int k = 0; k < N; k++) begin
      int idx = (rr + k) % N;
      if (!occ[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int next_rr(input int s);
`ifdef PARK_ROUND_ROBIN_EN
    return (s + 1) % N;
`else
    return s * 0;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_occ = '0;
    m_rr  = 0;
    for (int i = 0; i < N; i++) m_stay[i] = 0;
    exp_q.delete();
  endtask

  task automatic commit(input int s);
    m_occ[s] = 1'b1;
    m_rr     = next_rr(s);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_occ[i] && m_stay[i] < 15) m_stay[i]++;
    end
  endtask

  task automatic do_depart(input bit [N-1:0] mask);
    bus.depart = mask;
    step();
    bus.depart = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && m_occ[i]) begin
        m_occ[i]  = 1'b0;
        m_stay[i] = 0;
      end
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic full_check(input string tag);
    int free_n;
    free_n = N - $countones(m_occ);
    chk({tag, ":occ"}, int'(bus.occupied), int'(m_occ));
    chk({tag, ":empty"}, int'(bus.num_empty), free_n);
    chk({tag, ":green"}, int'(bus.green), int'(free_n != 0));
    chk({tag, ":gate"}, int'(bus.gate_open), 0);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s:stay%0d", tag, i), int'(bus.stay_sec[4*i +: 4]), m_stay[i]);
      chk($sformatf("%s:over%0d", tag, i), int'(bus.overstay[i]), int'(m_stay[i] >= MAXS));
    end
  endtask

  task automatic wait_event(input int target);
    int n;
    n = 0;
    while (ev_count < target && n < 40) begin
      step();
      n++;
    end
    if (ev_count < target) chk("event_timeout", ev_count, target);
  endtask

  task automatic run_gate();
    for (int t = 0; t < GOS; t++) begin
      chk("gate_hold", int'(bus.gate_open), 1);
      do_tick();
    end
    chk("gate_close", int'(bus.gate_open), 0);
  endtask

  task automatic pulse_arrive();
    bus.arrive = 1'b1;
    step();
    bus.arrive = 1'b0;
  endtask

  task automatic serve_one();
    int   s;
    int   base;
    exp_t e;
    s      = pick(m_occ, m_rr);
    base   = ev_count;
    e.rej  = (s < 0);
    e.slot = (s < 0) ? 0 : s;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    pulse_arrive();
    wait_event(base + 1);
    step();
    if (s >= 0) begin
      commit(s);
      run_gate();
    end
  endtask

  task automatic queued_arrivals();
    int         s1, s2, base, tmp_rr;
    bit [N-1:0] tmp;
    exp_t       e;
    s1     = pick(m_occ, m_rr);
    tmp    = m_occ;
    tmp[s1] = 1'b1;
    tmp_rr = next_rr(s1);
    s2     = pick(tmp, tmp_rr);
    base   = ev_count;
    e.rej = 1'b0; e.slot = s1; e.cyc = cyc + 2;
    exp_q.push_back(e);
    e.rej = 1'b0; e.slot = s2; e.cyc = -1;
    exp_q.push_back(e);
    pulse_arrive();
    wait_event(base + 1);
    step();
    commit(s1);
    for (int t = 0; t < GOS; t++) begin
      chk("q_gate_hold", int'(bus.gate_open), 1);
      do_tick();
      if (t == 0) begin
        pulse_arrive();
        step();
        pulse_arrive();
        step();
      end
    end
    chk("q_gate_close", int'(bus.gate_open), 0);
    chk("q_green_pending", int'(bus.green), 0);
    wait_event(base + 2);
    step();
    commit(s2);
    run_gate();
    repeat (6) step();
    chk("drop_third", ev_count, base + 2);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic reset_mid_gate();
    int   s;
    int   base;
    exp_t e;
    s      = pick(m_occ, m_rr);
    base   = ev_count;
    e.rej  = 1'b0;
    e.slot = s;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    pulse_arrive();
    wait_event(base + 1);
    step();
    commit(s);
    chk("rg_gate_hold", int'(bus.gate_open), 1);
    do_tick();
    reset = 1'b1;
    step();
    chk("rg_gate", int'(bus.gate_open), 0);
    chk("rg_occ", int'(bus.occupied), 0);
    chk("rg_empty", int'(bus.num_empty), N);
    reset = 1'b0;
    model_reset();
    full_check("rg");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit reached", $time);
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    tick       = 1'b0;
    bus.arrive = 1'b0;
    bus.depart = '0;
    model_reset();
    repeat (2) step();
    reset = 1'b0;

    chk("rst_gate", int'(bus.gate_open), 0);
    chk("rst_reject", int'(bus.reject), 0);
    chk("rst_valid", int'(bus.assign_valid), 0);
    chk("rst_slot", int'(bus.assign_slot), 0);
    chk("rst_over", int'(bus.overstay), 0);
    chk("rst_green", int'(bus.green), 1);
    chk("rst_empty", int'(bus.num_empty), N);
    full_check("rst");

    serve_one();
    chk("t1_occ", int'(bus.occupied), 1);
    chk("t1_empty", int'(bus.num_empty), 2);
    full_check("t1");

    serve_one();
    serve_one();
    chk("t2_green", int'(bus.green), 0);
    full_check("t2_full");
    serve_one();
    full_check("t2_rej");

    reset_dut();
    serve_one();
    serve_one();
    do_depart(3'b001);
    full_check("t3_dep");
    serve_one();
    full_check("t3");

    for (int t = 0; t < 20; t++) begin
      do_tick();
      full_check("t4_tick");
    end
    chk("t4_sat", int'(bus.stay_sec[7:4]), 15);
    do_depart(3'b010);
    chk("t4_clr", int'(bus.stay_sec[7:4]), 0);
    chk("t4_over", int'(bus.overstay[1]), 0);
    full_check("t4");

    reset_dut();
    queued_arrivals();
    full_check("t5");

    reset_dut();
    reset_mid_gate();
    serve_one();
    do_depart(3'b110);
    chk("t6_free_dep", int'(bus.occupied), 1);
    full_check("t6");

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: serve_one();
        1: do_depart(N'($urandom_range(0, (1 << N) - 1)));
        default: begin
          repeat ($urandom_range(1, 3)) do_tick();
        end
      endcase
      full_check("rnd");
    end

    repeat (4) step();
    chk("end_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
